// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider.
//   - State encodings for the divider FSM.
//   - Handshake level names for ready/start.
//   - Datapath widths and a two's-complement negation helper.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree     = 2'b00,
        DivByZero   = 2'b01,
        DivOn       = 2'b10,
        DivEnd      = 2'b11
    } div_state_e;

    // Two's-complement negate. 0x80000000 maps to itself, which is exactly
    // the magnitude needed for the most negative operand.
    function automatic logic [RegBus-1:0] twos_neg(input logic [RegBus-1:0] v);
        logic signed [RegBus-1:0] s;
        s = $signed(v);
        return $unsigned(-s);
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle 32-bit integer divider (DIV / DIVU) beside the execute stage.
// Restoring shift-subtract, one quotient bit per clock, followed by a sign
// fix-up cycle. Signed operands are converted to magnitudes on acceptance.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, level-held until the result is consumed
//   annul_i       cancel an in-flight divide (only honoured while iterating)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [RegBus-1:0]       rem_q, rem_d;       // partial remainder
    logic [RegBus-1:0]       quo_q, quo_d;       // dividend shifting out, quotient shifting in
    logic [RegBus-1:0]       dvs_q, dvs_d;       // divisor magnitude
    logic                    sgn_q, sgn_d;
    logic                    neg1_q, neg1_d;
    logic                    neg2_q, neg2_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [RegBus:0]         shifted;
    logic [RegBus:0]         trial;
    logic                    trial_ge;
    logic [RegBus-1:0]       quo_fix;
    logic [RegBus-1:0]       rem_fix;

    // Iteration datapath: the remainder stays below the divisor, so the
    // shifted value fits in 33 bits. When its top bit is set it certainly
    // exceeds the 32-bit divisor; otherwise bit 32 of the modular 33-bit
    // difference is the borrow.
    always_comb begin
        shifted  = {rem_q, quo_q[RegBus-1]};
        trial    = shifted - {1'b0, dvs_q};
        trial_ge = shifted[RegBus] | ~trial[RegBus];
        quo_fix  = (sgn_q && (neg1_q ^ neg2_q)) ? twos_neg(quo_q) : quo_q;
        rem_fix  = (sgn_q && neg1_q) ? twos_neg(rem_q) : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        quo_d   = (signed_div_i && opdata1_i[RegBus-1]) ? twos_neg(opdata1_i) : opdata1_i;
                        dvs_d   = (signed_div_i && opdata2_i[RegBus-1]) ? twos_neg(opdata2_i) : opdata2_i;
                        sgn_d   = signed_div_i;
                        neg1_d  = opdata1_i[RegBus-1];
                        neg2_d  = opdata2_i[RegBus-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = DivOn;
                    end
                end
            end

            DivByZero: begin
                result_d = '0;
                ready_d  = DivResultReady;
                state_d  = DivEnd;
            end

            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else if (cnt_q != 6'd32) begin
                    if (trial_ge) begin
                        rem_d = trial[RegBus-1:0];
                    end else begin
                        rem_d = shifted[RegBus-1:0];
                    end
                    quo_d = {quo_q[RegBus-2:0], trial_ge};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end

            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = DivFree;
                ready_d  = DivResultNotReady;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sgn_q    <= sgn_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the multi-cycle divider: directed cases, divide
// by zero, annul, asynchronous reset, back-to-back and randomized divides
// against an arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        sdiv;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int total;
    int bad;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sdiv),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division on 64-bit values. SV division
    // truncates toward zero and the remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue a divide and wait (bounded) for ready. Returns the result seen
    // with ready, the number of edges counted from the accepting edge, and
    // a timeout flag. Optionally scrambles operand inputs while waiting.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input bit scramble, output logic [63:0] res,
                          output int lat, output bit to);
        res = 64'd0;
        lat = 0;
        to  = 1'b1;
        @(negedge clk);
        opdata1 = a;
        opdata2 = b;
        sdiv    = sg;
        start   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (scramble) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
            if (ready) begin
                to  = 1'b0;
                res = result;
                break;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL reset: ready=%b result=%h required ready=0 result=0", ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL idle_after_reset: ready=%b result=%h required 0/0", ready, result);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic        ts [4];
        logic [63:0] te [4];
        logic [63:0] res;
        int          lat;
        bit          to;
        ta[0] = 32'd100;       tb[0] = 32'd7;          ts[0] = 1'b0; te[0] = 64'h00000002_0000000E;
        ta[1] = 32'hFFFFFFF9;  tb[1] = 32'h00000002;   ts[1] = 1'b1; te[1] = 64'hFFFFFFFF_FFFFFFFD;
        ta[2] = 32'hFFFFFFFF;  tb[2] = 32'h00000001;   ts[2] = 1'b0; te[2] = 64'h00000000_FFFFFFFF;
        ta[3] = 32'h80000000;  tb[3] = 32'hFFFFFFFF;   ts[3] = 1'b1; te[3] = 64'h00000000_80000000;
        for (int i = 0; i < 4; i++) begin
            do_div(ta[i], tb[i], ts[i], 1'b0, res, lat, to);
            total++;
            if (to || lat != 34) begin
                bad++;
                $display("FAIL directed_latency[%0d]: edges=%0d timeout=%0b required 34", i, lat, to);
            end
            total++;
            if (res !== te[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, te[i]);
            end
            @(posedge clk);
            #1;
            total++;
            if (ready !== 1'b1 || result !== te[i]) begin
                bad++;
                $display("FAIL directed_hold[%0d]: ready=%b result=%h required 1/%h", i, ready, result, te[i]);
            end
            release_start();
            total++;
            if (ready !== 1'b0 || result !== 64'd0) begin
                bad++;
                $display("FAIL directed_drop[%0d]: ready=%b result=%h required 0/0", i, ready, result);
            end
        end
    endtask

    task automatic test_div_by_zero();
        @(negedge clk);
        opdata1 = 32'd1234;
        opdata2 = 32'd0;
        sdiv    = 1'b0;
        start   = 1'b1;
        @(posedge clk);  // E0: accepted
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL dbz_early: ready=%b required 0 after first edge", ready);
        end
        annul = 1'b1;    // ignored outside iteration
        @(posedge clk);  // E1
        #1;
        total++;
        if (ready !== 1'b1 || result !== 64'd0) begin
            bad++;
            $display("FAIL dbz_ready: ready=%b result=%h required 1/0", ready, result);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (ready !== 1'b1 || result !== 64'd0) begin
                bad++;
                $display("FAIL dbz_hold[%0d]: ready=%b result=%h required 1/0", i, ready, result);
            end
        end
        annul = 1'b0;
        release_start();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL dbz_drop: ready=%b required 0", ready);
        end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int          lat;
        bit          to;
        int          seen;
        @(negedge clk);
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        sdiv    = 1'b0;
        start   = 1'b1;
        // After the accepting edge and ten iterations the count is 10.
        for (int i = 0; i < 11; i++) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) seen++;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL annul_no_ready: ready high %0d cycles required 0", seen);
        end
        do_div(32'd9, 32'd3, 1'b0, 1'b0, res, lat, to);
        total++;
        if (to || res !== 64'h00000000_00000003 || lat != 34) begin
            bad++;
            $display("FAIL annul_next: got %h edges=%0d required 0000000000000003 in 34", res, lat);
        end
        release_start();
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int          lat;
        bit          to;
        // Reset while a result is being presented.
        do_div(32'd1000, 32'd3, 1'b0, 1'b0, res, lat, to);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_end: ready=%b result=%h required 0/0", ready, result);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // Reset mid-divide, then a fresh divide must be unaffected.
        @(negedge clk);
        opdata1 = 32'hDEADBEEF;
        opdata2 = 32'd17;
        sdiv    = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 15; i++) @(posedge clk);
        #3;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL async_reset_mid: ready=%b result=%h required 0/0", ready, result);
        end
        @(negedge clk);
        rst = 1'b0;
        do_div(32'd50, 32'd6, 1'b0, 1'b0, res, lat, to);
        total++;
        if (to || res !== model(32'd50, 32'd6, 1'b0) || lat != 34) begin
            bad++;
            $display("FAIL after_reset_div: got %h edges=%0d required %h in 34", res, lat, model(32'd50, 32'd6, 1'b0));
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat;
        bit          to;
        logic [31:0] a, b;
        logic        sg;
        for (int i = 0; i < 4; i++) begin
            a  = $urandom;
            b  = $urandom_range(1, 1000);
            sg = 1'(i);
            do_div(a, b, sg, 1'b0, res, lat, to);
            total++;
            if (to || res !== model(a, b, sg) || lat != 34) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got %h edges=%0d required %h in 34", i, res, lat, model(a, b, sg));
            end
            release_start();
        end
    endtask

    task automatic test_random();
        logic [63:0] res;
        logic [63:0] exp;
        int          lat;
        int          exp_lat;
        bit          to;
        logic [31:0] a, b;
        logic        sg;
        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 16);
                2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                3: b = 32'h80000000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            exp     = model(a, b, sg);
            exp_lat = (b == 32'd0) ? 2 : 34;
            do_div(a, b, sg, 1'b1, res, lat, to);
            total++;
            if (to || res !== exp || lat != exp_lat) begin
                bad++;
                $display("FAIL random[%0d] a=%h b=%h s=%0b: got %h edges=%0d required %h in %0d",
                         i, a, b, sg, res, lat, exp, exp_lat);
            end
            release_start();
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        sdiv    = 1'b0;
        opdata1 = 32'd0;
        opdata2 = 32'd0;
        start   = 1'b0;
        annul   = 1'b0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider for DIV/DIVU, sitting beside the execute stage. The execute stage issues operands and a start request and holds the pipeline stalled while the divide runs. It consumes the 64-bit result on `ready_o` and forwards it as the HI/LO write. One quotient bit is produced per clock by restoring shift-subtract, with sign correction for signed operation.

## Interface

Parameters: none. Widths are fixed at 32-bit operands and a 64-bit result.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset: one clock; asynchronous, active-high.
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request.
  - Level-held by the execute stage until it has consumed the result.
- `annul_i`  in  1  cancel an in-flight divide (pipeline flush).
- `result_o`  out  64  result, registered.
  - `{remainder[31:0], quotient[31:0]}`: HI = remainder, LO = quotient.
- `ready_o`  out  1  result valid, registered.

## Operation

State machine, 2-bit state:
- **DivFree**
  - If `start_i`=1 and `annul_i`=0 and divisor = 0: go to DivByZero.
  - If `start_i`=1 and `annul_i`=0 and divisor ≠ 0:
    - latch operands;
    - when signed, latch the absolute values (two's-complement negate where bit 31 = 1);
    - latch `signed_div_i` and both operand sign bits;
    - clear the partial remainder and set `cnt`=0;
    - go to DivOn.
  - Otherwise stay. `ready_o`=0, `result_o`=0.
- **DivByZero**
  - Next edge: `result_o`=0, `ready_o`=1, go to DivEnd.
- **DivOn**
  - If `annul_i`=1: go to DivFree, `ready_o`=0, `result_o`=0, nothing committed.
  - Else, while `cnt`<32, each edge:
    - shift `{rem, dividend}` left by 1;
    - trial = `rem` − divisor (33-bit);
    - if trial is non-negative, `rem` = trial and shift in quotient bit 1, else shift in 0;
    - `cnt`++.
  - At `cnt`=32, next edge:
    - quotient negated if signed and operand signs differ;
    - remainder negated if signed and dividend negative;
    - `result_o` = `{rem, quo}`, `ready_o`=1, go to DivEnd.
- **DivEnd**
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0: next edge go to DivFree, `ready_o`=0, `result_o`=0.

Rules:
- Operand inputs are ignored after acceptance. Changes on `opdata*_i` while in DivOn have no effect.
- `annul_i` in DivByZero or DivEnd is ignored; the handshake completes normally.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Divide-by-zero gives result 0. No exception is raised here.

## Timing

- Edge E0 samples `start_i` in DivFree. Iterations run on E1..E32; sign fix on E33. `ready_o` is high after E33, i.e. 34 edges including the accepting one.
- Divide-by-zero: `ready_o` is high after E1.
- Back-to-back divides: a minimum of 1 cycle with `start_i`=0 is required between results, because DivEnd → DivFree takes one edge.
- Reset, asynchronous at any time including mid-divide:
  - state = DivFree, `cnt`=0;
  - `ready_o`=0, `result_o`=0;
  - internal registers = 0.
- Annul takes effect on the edge that samples it. `ready_o` never pulses for an annulled divide.

## Structure

Shared defines file:
- state encodings `DivFree`=2'b00, `DivByZero`=2'b01, `DivOn`=2'b10, `DivEnd`=2'b11;
- `DivResultReady`/`DivResultNotReady`;
- `DivStart`/`DivStop`;
- existing `RegBus` and `DoubleRegBus`.

Single flat module. No sub-module: the 33-bit subtractor and negators are inline.

## Test plan

- Unsigned 100 / 7 → `result_o`=0x00000002_0000000E; `ready_o` rises exactly 34 edges after start.
- Signed −7 / 2, i.e. 0xFFFFFFF9 / 0x00000002 → `result_o`=0xFFFFFFFF_FFFFFFFD.
- Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
- Divisor 0 → `ready_o` after 2 edges with `result_o`=0; result held until `start_i` drops, then `ready_o`=0 on the next edge.
- Start 100/7, assert `annul_i` at `cnt`=10 → DivFree, no `ready_o` pulse.
  - Then issue 9 / 3 → 0x00000000_00000003.
  - Also assert `rst` mid-divide → outputs 0 immediately (asynchronous).
